mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access: MEM-stage load/store unit that turns a pipeline memory
// instruction into one word-wide bus transaction and stalls the pipeline
// until the transaction completes or times out.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0)
//                raise a one-cycle misalign pulse and issue no bus request
//   undefined -> no misalign port; halfword accesses ignore addr[0], word
//                accesses ignore addr[1:0]
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   MEM_alu_result    effective byte address
//   MEM_rs2_data      store data
//   MEM_inst          instruction in MEM (funct3 = [14:12])
//   MEM_mem_re/we     load / store request
//   MEM_have_inst     MEM slot valid
//   MEM_ram_data      extended load result towards MEM/WB
//   mem_stall         pipeline freeze while an access is in progress
//   bus_req/we/addr/wdata/wstrb, bus_ack, bus_rdata, bus_err   memory bus
//   misalign          (MISALIGN_TRAP_EN only) misaligned-access pulse
//   state_dbg         current FSM state (IDLE=0, REQ=1, DONE=2)
//   inst_dbg          instruction of the most recently issued access
//
// Bus handshake: bus_req is a registered level that is high for every cycle
// the FSM sits in REQ; bus_addr/bus_we/bus_wdata/bus_wstrb are loaded on the
// edge that raises bus_req and stay constant until it falls. The slave
// completes the transfer by asserting bus_ack for one cycle (legal already in
// the first REQ cycle); bus_rdata is sampled on that same edge. A transfer
// that sees no bus_ack for TIMEOUT_CYCLES REQ cycles is abandoned and
// reported on bus_err.
// -----------------------------------------------------------------------------
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_rs2_data,
  input  logic [31:0] MEM_inst,
  input  logic        MEM_mem_re,
  input  logic        MEM_mem_we,
  input  logic        MEM_have_inst,
  output logic [31:0] MEM_ram_data,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [1:0]  state_dbg,
  output logic [31:0] inst_dbg
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_d;

  logic          access;
  logic          go;
  logic          timeout;
  logic [2:0]    f3;
  logic [3:0]    wstrb_d;
  logic [31:0]   wdata_d;
  logic [31:0]   inst_q;
  logic [1:0]    lo_q;
  logic [CW-1:0] cnt;
  logic [31:0]   ram_q;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  assign access    = MEM_have_inst && (MEM_mem_re || MEM_mem_we);
  assign f3        = MEM_inst[14:12];
  assign state_dbg = state;
  assign inst_dbg  = inst_q;

`ifdef MISALIGN_TRAP_EN
  logic mis;

  always_comb begin
    mis = 1'b0;
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = MEM_alu_result[0];
      default: mis = |MEM_alu_result[1:0];
    endcase
  end

  // A misaligned access never leaves IDLE, so the pipeline is not held and
  // the pulse lasts exactly the one cycle the instruction spends in MEM.
  assign go           = access && !mis;
  assign misalign     = access && mis && (state == ST_IDLE);
  assign MEM_ram_data = misalign ? 32'd0 : ram_q;
`else
  assign go           = access;
  assign MEM_ram_data = ram_q;
`endif

  // Store lane formatting; loads drive no strobes and zero data.
  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = 32'd0;
    if (MEM_mem_we) begin
      case (f3[1:0])
        2'b00: begin
          wstrb_d = 4'b0001 << MEM_alu_result[1:0];
          wdata_d = {4{MEM_rs2_data[7:0]}};
        end
        2'b01: begin
          wstrb_d = 4'b0011 << {MEM_alu_result[1], 1'b0};
          wdata_d = {2{MEM_rs2_data[15:0]}};
        end
        default: begin
          wstrb_d = 4'b1111;
          wdata_d = MEM_rs2_data;
        end
      endcase
    end
  end

  // Load lane select and extension, using the address/funct3 latched at issue.
  always_comb begin
    ld_byte = 8'd0;
    case (lo_q)
      2'd0: ld_byte = bus_rdata[7:0];
      2'd1: ld_byte = bus_rdata[15:8];
      2'd2: ld_byte = bus_rdata[23:16];
      2'd3: ld_byte = bus_rdata[31:24];
      default: ld_byte = 8'd0;
    endcase
    ld_half = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (inst_q[14:12])
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // Next state and stall
  always_comb begin
    state_d   = state;
    timeout   = 1'b0;
    mem_stall = go && (state != ST_DONE);
    case (state)
      ST_IDLE: if (go) state_d = ST_REQ;
      ST_REQ: begin
        // An ack in the last allowed cycle still counts as a completion.
        timeout = !bus_ack && (cnt == TO_LAST);
        if (bus_ack || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs, capture register, timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      bus_wstrb <= 4'd0;
      bus_err   <= 1'b0;
      inst_q    <= 32'd0;
      lo_q      <= 2'd0;
      cnt       <= '0;
      ram_q     <= 32'd0;
    end else begin
      bus_err <= 1'b0;
      bus_req <= (state_d == ST_REQ);
      if (state == ST_IDLE && go) begin
        bus_addr  <= {MEM_alu_result[31:2], 2'b00};
        bus_we    <= MEM_mem_we;
        bus_wdata <= wdata_d;
        bus_wstrb <= wstrb_d;
        inst_q    <= MEM_inst;
        lo_q      <= MEM_alu_result[1:0];
        cnt       <= '0;
      end
      if (state == ST_REQ) begin
        if (bus_ack) begin
          ram_q <= ld_ext;
        end else begin
          cnt <= cnt + 1'b1;
          if (timeout) begin
            ram_q   <= 32'd0;
            bus_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access built with TIMEOUT_CYCLES = 4. Inputs are driven 1 ns
// after the rising edge, outputs are sampled on the falling edge.
module tb_mem_access;

  localparam int TO    = 4;
  localparam int NEVER = 1000;

  logic        clk;
  logic        rst;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_rs2_data;
  logic [31:0] MEM_inst;
  logic        MEM_mem_re;
  logic        MEM_mem_we;
  logic        MEM_have_inst;
  logic [31:0] MEM_ram_data;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic [1:0]  state_dbg;
  logic [31:0] inst_dbg;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_alu_result (MEM_alu_result),
    .MEM_rs2_data   (MEM_rs2_data),
    .MEM_inst       (MEM_inst),
    .MEM_mem_re     (MEM_mem_re),
    .MEM_mem_we     (MEM_mem_we),
    .MEM_have_inst  (MEM_have_inst),
    .MEM_ram_data   (MEM_ram_data),
    .mem_stall      (mem_stall),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .bus_err        (bus_err),
`ifdef MISALIGN_TRAP_EN
    .misalign       (misalign),
`endif
    .state_dbg      (state_dbg),
    .inst_dbg       (inst_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load results are popped when the DUT reaches DONE for a load.
  always @(negedge clk) begin
    if (rst && state_dbg == 2'd2 && MEM_mem_re) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL ram_data_unexpected: got %h with empty queue", MEM_ram_data);
      end else begin
        exp_v = exp_q.pop_front();
        check("ram_data", MEM_ram_data, exp_v);
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;   // REQ cycle index carrying bus_ack, NEVER = none
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];
  vec_t tmp;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    @(posedge clk); #1;
    MEM_have_inst = 1'b0;
    MEM_mem_re    = 1'b0;
    MEM_mem_we    = 1'b0;
    bus_ack       = 1'b0;
  endtask

  task automatic drive_inst(input logic store, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata);
    MEM_have_inst  = 1'b1;
    MEM_mem_re     = !store;
    MEM_mem_we     = store;
    MEM_inst       = {17'd0, f3, 5'd0, (store ? 7'b0100011 : 7'b0000011)};
    MEM_alu_result = addr;
    MEM_rs2_data   = wdata;
  endtask

  // Runs one access to completion; returns at the falling edge inside DONE,
  // leaving the instruction in MEM so a following call is back-to-back.
  task automatic run_vec(input vec_t v);
    int req_cycles;
    int stall_cycles;
    bit done;
    @(posedge clk); #1;
    drive_inst(v.store, v.f3, v.addr, v.wdata);
    bus_rdata = v.rdata;
    bus_ack   = 1'b0;
    if (!v.store) exp_q.push_back(v.exp_rd);
    req_cycles   = 0;
    stall_cycles = 0;
    done         = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) stall_cycles++;
      if (state_dbg == 2'd2) begin
        done = 1;
      end else if (bus_req) begin
        check("bus_addr",  bus_addr,  v.addr & 32'hFFFF_FFFC);
        check("bus_we",    {31'd0, bus_we}, {31'd0, v.store});
        check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, v.exp_wstrb});
        check("bus_wdata", bus_wdata, v.exp_wdata);
        bus_ack = (req_cycles == v.ack_dly);
        req_cycles++;
      end
    end
    bus_ack = 1'b0;
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_wait: DONE not reached within 40 cycles (addr %h)", v.addr);
    end
    check("stall_cycles", stall_cycles, v.exp_stall);
    check("bus_err_done", {31'd0, bus_err}, {31'd0, v.exp_err});
    if (v.ack_dly == NEVER) check("timeout_req_cycles", req_cycles, TO);
  endtask

  // ---------------- test ----------------
  initial begin
    bit seen_req;
    rst            = 1'b0;
    MEM_alu_result = 32'd0;
    MEM_rs2_data   = 32'd0;
    MEM_inst       = 32'd0;
    MEM_mem_re     = 1'b0;
    MEM_mem_we     = 1'b0;
    MEM_have_inst  = 1'b0;
    bus_ack        = 1'b0;
    bus_rdata      = 32'd0;

    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1,     4'b1111, 32'hDEADBEEF, 32'h0,        3, 1'b0};
    vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF1234, 0,     4'b0000, 32'h0,        32'hFFFFFF80, 2, 1'b0};
    vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF1234, 0,     4'b0000, 32'h0,        32'h00000080, 2, 1'b0};
    vecs[3]  = '{1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0,        0,     4'b1100, 32'hABCDABCD, 32'h0,        2, 1'b0};
    vecs[4]  = '{1'b1, 3'b000, 32'h301, 32'h12345678, 32'h0,        2,     4'b0010, 32'h78787878, 32'h0,        4, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 32'h402, 32'h0,        32'h80017FFF, 1,     4'b0000, 32'h0,        32'hFFFF8001, 3, 1'b0};
    vecs[6]  = '{1'b0, 3'b101, 32'h400, 32'h0,        32'h12349ABC, 0,     4'b0000, 32'h0,        32'h00009ABC, 2, 1'b0};
    vecs[7]  = '{1'b0, 3'b010, 32'h504, 32'h0,        32'hCAFEF00D, 1,     4'b0000, 32'h0,        32'hCAFEF00D, 3, 1'b0};
    vecs[8]  = '{1'b0, 3'b000, 32'h600, 32'h0,        32'h0000007F, 0,     4'b0000, 32'h0,        32'h0000007F, 2, 1'b0};
    vecs[9]  = '{1'b0, 3'b001, 32'h600, 32'h0,        32'h00008000, 0,     4'b0000, 32'h0,        32'hFFFF8000, 2, 1'b0};
    vecs[10] = '{1'b1, 3'b000, 32'h000, 32'h000000A5, 32'h0,        0,     4'b0001, 32'hA5A5A5A5, 32'h0,        2, 1'b0};
    vecs[11] = '{1'b0, 3'b010, 32'h700, 32'h0,        32'h55555555, NEVER, 4'b0000, 32'h0,        32'h0,        1 + TO, 1'b1};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_state",     {30'd0, state_dbg}, 32'd0);
    check("rst_bus_req",   {31'd0, bus_req}, 32'd0);
    check("rst_bus_we",    {31'd0, bus_we}, 32'd0);
    check("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    check("rst_bus_addr",  bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_ram_data",  MEM_ram_data, 32'd0);
    check("rst_bus_err",   {31'd0, bus_err}, 32'd0);
    @(posedge clk); #3;
    rst = 1'b1;

    // Non-memory instruction and invalid slot: no stall, no bus activity
    @(posedge clk); #1;
    MEM_have_inst = 1'b1;
    MEM_inst      = 32'h00000013;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nonmem_stall",   {31'd0, mem_stall}, 32'd0);
      check("nonmem_bus_req", {31'd0, bus_req}, 32'd0);
    end
    @(posedge clk); #1;
    MEM_have_inst = 1'b0;
    MEM_mem_re    = 1'b1;
    @(negedge clk);
    check("invalid_slot_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    check("invalid_slot_state", {30'd0, state_dbg}, 32'd0);

    // Table: consecutive vectors run back-to-back
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // After the timeout: error pulse gone, zero result held
    drive_idle();
    @(negedge clk);
    check("err_pulse_end", {31'd0, bus_err}, 32'd0);
    check("idle_after_to", {30'd0, state_dbg}, 32'd0);
    check("to_data_held",  MEM_ram_data, 32'd0);

    // Load result held over idle cycles
    tmp = '{1'b0, 3'b010, 32'h804, 32'h0, 32'h2468ACE1, 0, 4'b0000, 32'h0, 32'h2468ACE1, 2, 1'b0};
    run_vec(tmp);
    drive_idle();
    repeat (2) @(negedge clk);
    check("ram_data_hold", MEM_ram_data, 32'h2468ACE1);

    // Reset asserted in REQ abandons the access
    @(posedge clk); #1;
    drive_inst(1'b0, 3'b010, 32'h900, 32'h0);
    bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("async_rst_state",   {30'd0, state_dbg}, 32'd0);
    check("async_rst_ram",     MEM_ram_data, 32'd0);
    MEM_have_inst = 1'b0;
    MEM_mem_re    = 1'b0;
    bus_ack       = 1'b1;
    bus_rdata     = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    check("post_rst_state",   {30'd0, state_dbg}, 32'd0);
    check("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("post_rst_ram",     MEM_ram_data, 32'd0);
    @(negedge clk);
    check("post_rst_ram2",    MEM_ram_data, 32'd0);
    bus_ack = 1'b0;

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load is trapped without touching the bus
    @(posedge clk); #1;
    drive_inst(1'b0, 3'b010, 32'h101, 32'h0);
    @(negedge clk);
    check("mis_pulse",   {31'd0, misalign}, 32'd1);
    check("mis_stall",   {31'd0, mem_stall}, 32'd0);
    check("mis_bus_req", {31'd0, bus_req}, 32'd0);
    check("mis_ram",     MEM_ram_data, 32'd0);
    drive_idle();
    seen_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_req) seen_req = 1'b1;
    end
    check("mis_pulse_end", {31'd0, misalign}, 32'd0);
    check("mis_no_req",    {31'd0, seen_req}, 32'd0);
`else
    // Without the trap, low address bits are ignored for halfword/word
    tmp = '{1'b0, 3'b010, 32'h101, 32'h0, 32'h13579BDF, 0, 4'b0000, 32'h0, 32'h13579BDF, 2, 1'b0};
    run_vec(tmp);
    tmp = '{1'b1, 3'b001, 32'h203, 32'h00001234, 32'h0, 1, 4'b1100, 32'h12341234, 32'h0, 3, 1'b0};
    run_vec(tmp);
    drive_idle();
    seen_req = 1'b0;
    repeat (2) @(negedge clk);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
